// File: rtl/multicycle_control.sv
// Multicycle sequencer for the RV datapath.
// Walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, handshakes with instruction
// and data memories, issues PC/IR/register/memory strobes, counts retired
// instructions and traps illegal formats or memory timeouts into ERROR.
// The decoder's `type` field arrives on instr_type because `type` is a
// reserved word in SystemVerilog.
module multicycle_control #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop_req,
   input  logic [2:0]           instr_type,
   input  logic                 branch_taken,
   input  logic                 imem_ack,
   input  logic                 dmem_ack,
   output logic [3:0]           state,
   output logic                 imem_req,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_src,
   output logic                 reg_write,
   output logic                 busy,
   output logic                 err,
   output logic [CNT_WIDTH-1:0] retired
);

   localparam logic [3:0] S_IDLE      = 4'b1000;
   localparam logic [3:0] S_FETCH     = 4'b0000;
   localparam logic [3:0] S_DECODE    = 4'b0001;
   localparam logic [3:0] S_EXECUTE   = 4'b0010;
   localparam logic [3:0] S_MEMORY    = 4'b0011;
   localparam logic [3:0] S_WRITEBACK = 4'b0100;
   localparam logic [3:0] S_ERROR     = 4'b1110;

   localparam logic [2:0] T_LOAD   = 3'b000;
   localparam logic [2:0] T_IALU   = 3'b001;
   localparam logic [2:0] T_STORE  = 3'b010;
   localparam logic [2:0] T_R      = 3'b011;
   localparam logic [2:0] T_BRANCH = 3'b110;

   // The wait counter only ever holds 0..TIMEOUT-1; reaching the last value
   // with the ack still low is the timeout.
   localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [3:0]        state_next;
   logic              retire;
   logic              wait_inc;
   logic              stop_pend;
   logic              mem_store;
   logic [WAIT_W-1:0] wait_cnt;

   // Next-state and strobe decode from the registered state and live inputs
   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      wait_inc   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write   = 1'b1;
               state_next = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
               state_next = S_ERROR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_DECODE: begin
            state_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            case (instr_type)
               T_R, T_IALU:     state_next = S_WRITEBACK;
               T_LOAD, T_STORE: state_next = S_MEMORY;
               T_BRANCH: begin
                  pc_write = 1'b1;
                  pc_src   = branch_taken;
                  retire   = 1'b1;
               end
               default:         state_next = S_ERROR;
            endcase
         end
         S_MEMORY: begin
            dmem_req = 1'b1;
            dmem_we  = mem_store;
            if (dmem_ack) begin
               if (mem_store) begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end else begin
                  state_next = S_WRITEBACK;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               state_next = S_ERROR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_WRITEBACK: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
         end
         S_ERROR: begin
            state_next = S_ERROR;
         end
         default: begin
            state_next = S_ERROR;
         end
      endcase
      // A stop requested in the retiring cycle itself still counts
      if (retire) state_next = (stop_pend || stop_req) ? S_IDLE : S_FETCH;
   end

   assign busy = (state != S_IDLE) && (state != S_ERROR);

   // State register, retired counter and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         retired <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_next;
         if (retire) retired <= retired + 1'b1;
         if (state_next == S_ERROR) err <= 1'b1;
      end
   end

   // Pending-stop flag: armed by stop_req while running, or together with start in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stop_pend <= 1'b0;
      end else if (state == S_IDLE) begin
         stop_pend <= start && stop_req;
      end else if (retire) begin
         stop_pend <= 1'b0;
      end else if (stop_req) begin
         stop_pend <= 1'b1;
      end
   end

   // Ack wait counter, cleared whenever the state changes so each FETCH/MEMORY visit starts at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state_next != state) begin
         wait_cnt <= '0;
      end else if (wait_inc) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Remember load vs store when leaving EXECUTE so MEMORY does not depend on the decoder holding type
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_store <= 1'b0;
      end else if (state == S_EXECUTE) begin
         mem_store <= (instr_type == T_STORE);
      end
   end

endmodule
